// File: rtl/multi_run_ctrl.sv
// Run controller for the multi-cycle MIPS core: reset stretch, clock enable,
// cycle counting, free-run / single-step and stop on limit, halt or breakpoint.
module multi_run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int PC_W       = 32,
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             step,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  halt_pc,
    input  logic             halt_pc_en,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic             running,
    output logic             done,
    output logic [1:0]       done_cause,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MAX_CYCLES - 1);
    localparam bit LIMITED = (MAX_CYCLES != 0);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_LIMIT = 2'b01;
    localparam logic [1:0] CAUSE_HALT  = 2'b10;
    localparam logic [1:0] CAUSE_BRK   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        RUN,
        STEP_WAIT,
        STEP_EXEC,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [HOLD_W-1:0]  hold, hold_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         cause, cause_nxt;
    logic               brk_hit;
    logic               limit_hit;

    assign cpu_rst    = (state == IDLE) || (state == RST_HOLD);
    assign cpu_en     = (state == RUN) || (state == STEP_EXEC);
    assign running    = (state == RST_HOLD) || (state == RUN) ||
                        (state == STEP_WAIT) || (state == STEP_EXEC);
    assign done       = (state == DONE);
    assign done_cause = cause;
    assign cycle_cnt  = cnt;

    assign brk_hit   = halt_pc_en && (pc == halt_pc);
    assign limit_hit = LIMITED && cpu_en && (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        cnt_nxt   = cnt;
        cause_nxt = cause;

        // Saturation only matters for unlimited runs; limited runs stop first.
        if (cpu_en && (cnt != '1)) begin
            cnt_nxt = cnt + 1'b1;
        end

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RST_HOLD;
                    hold_nxt  = HOLD_LOAD;
                    cnt_nxt   = '0;
                    cause_nxt = CAUSE_NONE;
                end
            end
            RST_HOLD: begin
                if (hold == '0) begin
                    state_nxt = mode ? STEP_WAIT : RUN;
                end else begin
                    hold_nxt = hold - 1'b1;
                end
            end
            RUN, STEP_WAIT, STEP_EXEC: begin
                if (halt_req) begin
                    state_nxt = DONE;
                    cause_nxt = CAUSE_HALT;
                end else if (brk_hit) begin
                    state_nxt = DONE;
                    cause_nxt = CAUSE_BRK;
                end else if (limit_hit) begin
                    state_nxt = DONE;
                    cause_nxt = CAUSE_LIMIT;
                end else if (state == RUN) begin
                    if (mode) state_nxt = STEP_WAIT;
                end else if (state == STEP_WAIT) begin
                    if (!mode)     state_nxt = RUN;
                    else if (step) state_nxt = STEP_EXEC;
                end else begin
                    state_nxt = mode ? STEP_WAIT : RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hold  <= '0;
            cnt   <= '0;
            cause <= CAUSE_NONE;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            cnt   <= cnt_nxt;
            cause <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_multi_run_ctrl.sv
// Bench for multi_run_ctrl: directed scenarios plus randomized stop points
// and step patterns checked against an arithmetic run model.
module tb_multi_run_ctrl;

    localparam int CNT_W = 32;
    localparam int PC_W  = 32;
    localparam int RSTC  = 4;
    localparam int MAXC  = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic             step;
    logic             halt_req;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  halt_pc;
    logic             halt_pc_en;
    logic             cpu_rst;
    logic             cpu_en;
    logic             running;
    logic             done;
    logic [1:0]       done_cause;
    logic [CNT_W-1:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    multi_run_ctrl #(
        .CNT_W(CNT_W),
        .PC_W(PC_W),
        .RST_CYCLES(RSTC),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
        .step(step),
        .halt_req(halt_req),
        .pc(pc),
        .halt_pc(halt_pc),
        .halt_pc_en(halt_pc_en),
        .cpu_rst(cpu_rst),
        .cpu_en(cpu_en),
        .running(running),
        .done(done),
        .done_cause(done_cause),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts reset-hold and enabled cycles from now until done, bounded.
    task automatic measure(output int rc, output int ec, output bit ok);
        rc = 0;
        ec = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (cpu_rst) rc++;
            if (cpu_en) ec++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (cpu_rst !== 1'b1 || cpu_en !== 1'b0 || running !== 1'b0 ||
            done !== 1'b0 || done_cause !== 2'b00 || cycle_cnt !== '0) begin
            errors++;
            $display("FAIL reset_vals rst=%b en=%b run=%b done=%b cause=%b cnt=%0d want 1 0 0 0 00 0",
                     cpu_rst, cpu_en, running, done, done_cause, cycle_cnt);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (cpu_rst !== 1'b1 || running !== 1'b0 || cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold rst=%b run=%b en=%b want 1 0 0",
                     cpu_rst, running, cpu_en);
        end
    endtask

    task automatic test_free_run();
        int rc, ec;
        bit ok;
        mode = 1'b0;
        do_start();
        measure(rc, ec, ok);
        checks++;
        if (!ok || rc != RSTC || ec != MAXC) begin
            errors++;
            $display("FAIL free_run ok=%0b rst_cycles=%0d en_cycles=%0d want 1 %0d %0d",
                     ok, rc, ec, RSTC, MAXC);
        end
        checks++;
        if (done_cause !== 2'b01 || cycle_cnt !== CNT_W'(MAXC) ||
            cpu_en !== 1'b0 || cpu_rst !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL free_run_done cause=%b cnt=%0d en=%b rst=%b run=%b want 01 %0d 0 0 0",
                     done_cause, cycle_cnt, cpu_en, cpu_rst, running, MAXC);
        end
    endtask

    task automatic test_restart();
        int rc, ec;
        bit ok;
        do_start();
        checks++;
        if (done_cause !== 2'b00 || cycle_cnt !== '0 || cpu_rst !== 1'b1 ||
            done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear cause=%b cnt=%0d rst=%b done=%b want 00 0 1 0",
                     done_cause, cycle_cnt, cpu_rst, done);
        end
        measure(rc, ec, ok);
        checks++;
        if (!ok || rc != RSTC || ec != MAXC || done_cause !== 2'b01) begin
            errors++;
            $display("FAIL restart_run ok=%0b rc=%0d ec=%0d cause=%b want 1 %0d %0d 01",
                     ok, rc, ec, done_cause, RSTC, MAXC);
        end
    endtask

    task automatic test_step();
        int ec = 0;
        mode = 1'b1;
        do_start();
        repeat (RSTC) tick();
        checks++;
        if (running !== 1'b1 || cpu_en !== 1'b0 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL step_wait run=%b en=%b rst=%b want 1 0 0",
                     running, cpu_en, cpu_rst);
        end
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            checks++;
            if (cpu_en !== 1'b1) begin
                errors++;
                $display("FAIL step_pulse%0d en=%b want 1", p, cpu_en);
            end
            ec++;
            repeat (4) begin
                tick();
                if (cpu_en) ec++;
            end
        end
        checks++;
        if (ec != 3 || cycle_cnt !== 32'd3 || done !== 1'b0) begin
            errors++;
            $display("FAIL step_total en_cycles=%0d cnt=%0d done=%b want 3 3 0",
                     ec, cycle_cnt, done);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if (done !== 1'b1 || done_cause !== 2'b10 || cycle_cnt !== 32'd3) begin
            errors++;
            $display("FAIL step_halt done=%b cause=%b cnt=%0d want 1 10 3",
                     done, done_cause, cycle_cnt);
        end
        mode = 1'b0;
    endtask

    // Free run where the core model's pc advances by 4 per enabled cycle;
    // the stop is placed in enabled cycle h by breakpoint, halt_req or both.
    task automatic stop_run(input int kind, input int h, output int ec,
                            output bit ok);
        ec = 0;
        ok = 1'b0;
        pc = '0;
        halt_pc = PC_W'(4 * (h - 1));
        halt_pc_en = (kind != 0);
        mode = 1'b0;
        do_start();
        for (int i = 0; i < 400; i++) begin
            tick();
            halt_req = 1'b0;
            if (cpu_en) begin
                pc = PC_W'(4 * ec);
                ec++;
                if (ec == h && kind != 1) halt_req = 1'b1;
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        halt_req = 1'b0;
        halt_pc_en = 1'b0;
        pc = '0;
    endtask

    task automatic test_breakpoint();
        int ec;
        bit ok;
        halt_pc = 32'h10;
        stop_run(1, 5, ec, ok);
        checks++;
        if (!ok || ec != 5 || done_cause !== 2'b11 || cycle_cnt !== 32'd5 ||
            cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL breakpoint ok=%0b ec=%0d cause=%b cnt=%0d en=%b want 1 5 11 5 0",
                     ok, ec, done_cause, cycle_cnt, cpu_en);
        end
    endtask

    task automatic test_priority();
        int ec;
        bit ok;
        stop_run(2, 5, ec, ok);
        checks++;
        if (!ok || done_cause !== 2'b10 || cycle_cnt !== 32'd5) begin
            errors++;
            $display("FAIL halt_priority ok=%0b cause=%b cnt=%0d want 1 10 5",
                     ok, done_cause, cycle_cnt);
        end
    endtask

    task automatic test_async_reset();
        int ec = 0;
        int rc;
        bit ok;
        mode = 1'b0;
        do_start();
        for (int i = 0; i < 100 && ec < 21; i++) begin
            tick();
            if (cpu_en) ec++;
        end
        checks++;
        if (cycle_cnt !== 32'd20 || cpu_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_cnt cnt=%0d en=%b want 20 1", cycle_cnt, cpu_en);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cpu_en !== 1'b0 || cpu_rst !== 1'b1 || cycle_cnt !== '0 ||
            running !== 1'b0) begin
            errors++;
            $display("FAIL async_reset en=%b rst=%b cnt=%0d run=%b want 0 1 0 0",
                     cpu_en, cpu_rst, cycle_cnt, running);
        end
        #10;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (running !== 1'b0 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle run=%b rst=%b want 0 1", running, cpu_rst);
        end
        do_start();
        measure(rc, ec, ok);
        checks++;
        if (!ok || rc != RSTC || ec != MAXC || done_cause !== 2'b01 ||
            cycle_cnt !== CNT_W'(MAXC)) begin
            errors++;
            $display("FAIL rerun ok=%0b rc=%0d ec=%0d cause=%b cnt=%0d want 1 %0d %0d 01 %0d",
                     ok, rc, ec, done_cause, cycle_cnt, RSTC, MAXC, MAXC);
        end
    endtask

    task automatic test_random_stops();
        int kind, h, ec, exp_cnt;
        logic [1:0] exp_cause;
        bit ok;
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 2);
            h = $urandom_range(1, MAXC + 3);
            if (h > MAXC) begin
                exp_cause = 2'b01;
                exp_cnt = MAXC;
            end else begin
                exp_cause = (kind == 1) ? 2'b11 : 2'b10;
                exp_cnt = h;
            end
            stop_run(kind, h, ec, ok);
            checks++;
            if (!ok || done_cause !== exp_cause || cycle_cnt !== CNT_W'(exp_cnt) ||
                ec != exp_cnt) begin
                errors++;
                $display("FAIL rand_stop it=%0d kind=%0d h=%0d ok=%0b cause=%b cnt=%0d ec=%0d want %b %0d",
                         it, kind, h, ok, done_cause, cycle_cnt, ec, exp_cause, exp_cnt);
            end
        end
    endtask

    // A step pulse is taken only when the previous pulse was not taken on
    // the immediately preceding edge (that edge leaves the core executing).
    task automatic test_random_steps();
        int n, gap, ec, accepted;
        bit prev_taken;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 6);
            ec = 0;
            accepted = 0;
            prev_taken = 1'b0;
            gap = 2;
            mode = 1'b1;
            do_start();
            repeat (RSTC) tick();
            for (int p = 0; p < n; p++) begin
                if (p == 0 || gap > 1 || !prev_taken) begin
                    accepted++;
                    prev_taken = 1'b1;
                end else begin
                    prev_taken = 1'b0;
                end
                if (p > 0 && gap > 1) prev_taken = 1'b1;
                step = 1'b1;
                tick();
                step = 1'b0;
                if (cpu_en) ec++;
                gap = $urandom_range(1, 3);
                repeat (gap - 1) begin
                    tick();
                    if (cpu_en) ec++;
                end
            end
            repeat (2) begin
                tick();
                if (cpu_en) ec++;
            end
            checks++;
            if (ec != accepted || cycle_cnt !== CNT_W'(accepted) || done !== 1'b0) begin
                errors++;
                $display("FAIL rand_step it=%0d n=%0d en=%0d cnt=%0d done=%b want %0d",
                         it, n, ec, cycle_cnt, done, accepted);
            end
            halt_req = 1'b1;
            tick();
            halt_req = 1'b0;
        end
        mode = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        step = 1'b0;
        halt_req = 1'b0;
        pc = '0;
        halt_pc = '0;
        halt_pc_en = 1'b0;
        test_reset();
        test_free_run();
        test_restart();
        test_step();
        test_breakpoint();
        test_priority();
        test_async_reset();
        test_random_stops();
        test_random_steps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
